// File: rtl/dcache_mshr_if.sv
// Bus bundle between one data-cache bank's MSHR file and its neighbours.
// The neighbours are the cache miss port, the memory request/response
// channel, the cache fill port and the LSQ wake-up.
// The MSHR file is the responder and uses the slave modport.
interface dcache_mshr_if #(
  parameter int unsigned LINE_BITS = 128
);
  logic                 alloc;
  logic [31:0]          alloc_addr;
  logic [2:0]           mshr_wr_idx;
  logic                 mshr_full;
  logic                 alloc_ok;
  logic                 mem_req_valid;
  logic [31:0]          mem_req_addr;
  logic [2:0]           mem_req_tag;
  logic                 mem_req_ready;
  logic                 mem_resp_valid;
  logic [2:0]           mem_resp_tag;
  logic [LINE_BITS-1:0] mem_resp_data;
  logic                 fill_valid;
  logic [31:0]          fill_addr;
  logic [LINE_BITS-1:0] fill_data;
  logic                 mshr_fin;
  logic [2:0]           mshr_fin_idx;

  modport master (
    output alloc, alloc_addr, mem_req_ready, mem_resp_valid, mem_resp_tag, mem_resp_data,
    input  mshr_wr_idx, mshr_full, alloc_ok, mem_req_valid, mem_req_addr, mem_req_tag,
           fill_valid, fill_addr, fill_data, mshr_fin, mshr_fin_idx
  );

  modport slave (
    input  alloc, alloc_addr, mem_req_ready, mem_resp_valid, mem_resp_tag, mem_resp_data,
    output mshr_wr_idx, mshr_full, alloc_ok, mem_req_valid, mem_req_addr, mem_req_tag,
           fill_valid, fill_addr, fill_data, mshr_fin, mshr_fin_idx
  );
endinterface

// File: rtl/dcache_mshr.sv
// Miss status holding register file for one data-cache bank.
// Primary misses allocate an entry and issue one line request.
// Secondary misses to the same line merge into the existing entry.
// Fills are handed to the cache write port, with a one-cycle fin pulse to the LSQ.
module dcache_mshr #(
  parameter int unsigned ENTRIES   = 8,
  parameter int unsigned LINE_OFF  = 4,
  parameter int unsigned LINE_BITS = 128
) (
  input logic          clk,
  input logic          rst,
  dcache_mshr_if.slave bus
);
  localparam int unsigned LA_W = 32 - LINE_OFF;

  localparam logic [1:0] FREE       = 2'd0;
  localparam logic [1:0] WAIT_ISSUE = 2'd1;
  localparam logic [1:0] WAIT_RESP  = 2'd2;
  localparam logic [1:0] FILL       = 2'd3;

  logic [1:0]           state_q   [ENTRIES];
  logic [1:0]           state_n   [ENTRIES];
  logic [LA_W-1:0]      line_q    [ENTRIES];
  logic [3:0]           merge_cnt [ENTRIES];
  logic [LINE_BITS-1:0] fill_data_q;

  logic                 req_valid_q;
  logic [LA_W-1:0]      req_line_q;
  logic [2:0]           req_tag_q;

  logic [LA_W-1:0]      alloc_line;
  logic                 hit;
  logic [2:0]           hit_idx;
  logic                 free_any;
  logic [2:0]           free_idx;
  logic                 fill_any;
  logic [2:0]           fill_idx;
  logic                 do_alloc;
  logic                 req_fire;
  logic                 resp_hit;
  logic                 nxt_valid;
  logic [2:0]           nxt_tag;
  logic [LA_W-1:0]      nxt_line;

  assign alloc_line = bus.alloc_addr[31:LINE_OFF];

  // Associative lookup: merge target, lowest FREE entry, and the (single) FILL entry.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    fill_any = 1'b0;
    fill_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (state_q[i] != FREE && line_q[i] == alloc_line && !hit) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
      if (state_q[i] == FREE && !free_any) begin
        free_any = 1'b1;
        free_idx = 3'(i);
      end
      if (state_q[i] == FILL) begin
        fill_any = 1'b1;
        fill_idx = 3'(i);
      end
    end
  end

  assign do_alloc = bus.alloc && !hit && free_any;
  assign req_fire = req_valid_q && bus.mem_req_ready;
  assign resp_hit = bus.mem_resp_valid && (32'(bus.mem_resp_tag) < ENTRIES) &&
                    (state_q[bus.mem_resp_tag] == WAIT_RESP);

  // Next entry states; alloc, issue and response always touch distinct entries.
  always_comb begin
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      state_n[i] = (state_q[i] == FILL) ? FREE : state_q[i];
    end
    if (do_alloc) state_n[free_idx]         = WAIT_ISSUE;
    if (req_fire) state_n[req_tag_q]        = WAIT_RESP;
    if (resp_hit) state_n[bus.mem_resp_tag] = FILL;
  end

  // Request selection runs on next state so a miss at t can be on the bus at t+1;
  // the address of an entry allocated this cycle is taken straight from the miss.
  always_comb begin
    nxt_valid = 1'b0;
    nxt_tag   = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (state_n[i] == WAIT_ISSUE && !nxt_valid) begin
        nxt_valid = 1'b1;
        nxt_tag   = 3'(i);
      end
    end
    nxt_line = '0;
    if (nxt_valid) nxt_line = (do_alloc && nxt_tag == free_idx) ? alloc_line : line_q[nxt_tag];
  end

  // Entry state, line addresses, merge counts and captured fill data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        state_q[i]   <= FREE;
        line_q[i]    <= '0;
        merge_cnt[i] <= '0;
      end
      fill_data_q <= '0;
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) state_q[i] <= state_n[i];
      if (do_alloc) begin
        line_q[free_idx]    <= alloc_line;
        merge_cnt[free_idx] <= '0;
      end
      if (bus.alloc && hit) merge_cnt[hit_idx] <= merge_cnt[hit_idx] + 4'd1;
      if (resp_hit) fill_data_q <= bus.mem_resp_data;
    end
  end

  // Registered request channel, frozen while memory is not ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_valid_q <= 1'b0;
      req_line_q  <= '0;
      req_tag_q   <= '0;
    end else if (!req_valid_q || bus.mem_req_ready) begin
      req_valid_q <= nxt_valid;
      req_line_q  <= nxt_line;
      req_tag_q   <= nxt_tag;
    end
  end

  assign bus.mshr_wr_idx   = hit ? hit_idx : free_idx;
  assign bus.mshr_full     = !free_any;
  assign bus.alloc_ok      = hit || free_any;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = {req_line_q, {LINE_OFF{1'b0}}};
  assign bus.mem_req_tag   = req_tag_q;
  assign bus.fill_valid    = fill_any;
  assign bus.fill_addr     = fill_any ? {line_q[fill_idx], {LINE_OFF{1'b0}}} : '0;
  assign bus.fill_data     = fill_any ? fill_data_q : '0;
  assign bus.mshr_fin      = fill_any;
  assign bus.mshr_fin_idx  = fill_idx;
endmodule

// File: tb/tb_dcache_mshr.sv
// Self-checking bench for dcache_mshr: scenario tasks plus request/fin scoreboards.
module tb_dcache_mshr;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  tag;
  } req_t;

  typedef struct {
    logic [2:0]   idx;
    logic [31:0]  addr;
    logic [127:0] data;
  } fin_t;

  req_t exp_req[$];
  fin_t exp_fin[$];

  dcache_mshr_if #(.LINE_BITS(128)) bus ();

  dcache_mshr #(.ENTRIES(8), .LINE_OFF(4), .LINE_BITS(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Request scoreboard: every accepted request must be the next expected one.
  always @(negedge clk) begin
    if (rst && bus.mem_req_valid && bus.mem_req_ready) begin
      vectors++;
      if (exp_req.size() == 0) begin
        miscompares++;
        $display("FAIL req_unexpected: got addr=%h tag=%0d, required none", bus.mem_req_addr, bus.mem_req_tag);
      end else begin
        req_t e;
        e = exp_req.pop_front();
        if (bus.mem_req_addr !== e.addr || bus.mem_req_tag !== e.tag) begin
          miscompares++;
          $display("FAIL req_match: got addr=%h tag=%0d, required addr=%h tag=%0d",
                   bus.mem_req_addr, bus.mem_req_tag, e.addr, e.tag);
        end
      end
    end
  end

  // Fin scoreboard: each fin pulse must match the next expected fill.
  always @(negedge clk) begin
    if (rst && bus.mshr_fin) begin
      vectors++;
      if (exp_fin.size() == 0) begin
        miscompares++;
        $display("FAIL fin_unexpected: got idx=%0d, required none", bus.mshr_fin_idx);
      end else begin
        fin_t e;
        e = exp_fin.pop_front();
        if (bus.mshr_fin_idx !== e.idx || bus.fill_addr !== e.addr ||
            bus.fill_data !== e.data || bus.fill_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL fin_match: got idx=%0d addr=%h valid=%b data=%h, required idx=%0d addr=%h data=%h",
                   bus.mshr_fin_idx, bus.fill_addr, bus.fill_valid, bus.fill_data, e.idx, e.addr, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc          = 1'b0;
    bus.alloc_addr     = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_tag   = '0;
    bus.mem_resp_data  = '0;
  endtask

  task automatic respond(input logic [2:0] tag, input logic [31:0] line_addr);
    fin_t f;
    f.idx  = tag;
    f.addr = line_addr;
    f.data = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_tag   = tag;
    bus.mem_resp_data  = f.data;
    exp_fin.push_back(f);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors += 11;
    if (bus.mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid: got %b, required 0", bus.mem_req_valid); end
    if (bus.fill_valid !== 1'b0)    begin miscompares++; $display("FAIL rst_fill_valid: got %b, required 0", bus.fill_valid); end
    if (bus.mshr_fin !== 1'b0)      begin miscompares++; $display("FAIL rst_fin: got %b, required 0", bus.mshr_fin); end
    if (bus.mshr_fin_idx !== 3'd0)  begin miscompares++; $display("FAIL rst_fin_idx: got %0d, required 0", bus.mshr_fin_idx); end
    if (bus.mem_req_addr !== 32'd0) begin miscompares++; $display("FAIL rst_req_addr: got %h, required 0", bus.mem_req_addr); end
    if (bus.mem_req_tag !== 3'd0)   begin miscompares++; $display("FAIL rst_req_tag: got %0d, required 0", bus.mem_req_tag); end
    if (bus.fill_addr !== 32'd0)    begin miscompares++; $display("FAIL rst_fill_addr: got %h, required 0", bus.fill_addr); end
    if (bus.fill_data !== 128'd0)   begin miscompares++; $display("FAIL rst_fill_data: got %h, required 0", bus.fill_data); end
    if (bus.mshr_full !== 1'b0)     begin miscompares++; $display("FAIL rst_full: got %b, required 0", bus.mshr_full); end
    if (bus.mshr_wr_idx !== 3'd0)   begin miscompares++; $display("FAIL rst_wr_idx: got %0d, required 0", bus.mshr_wr_idx); end
    if (bus.alloc_ok !== 1'b1)      begin miscompares++; $display("FAIL rst_alloc_ok: got %b, required 1", bus.alloc_ok); end
    step();
    rst = 1'b1;
  endtask

  task automatic test_one_miss();
    step();
    bus.alloc = 1'b1;
    bus.alloc_addr = 32'h1000;
    exp_req.push_back('{32'h1000, 3'd0});
    @(negedge clk);
    vectors++;
    if (bus.mshr_wr_idx !== 3'd0) begin miscompares++; $display("FAIL one_wr_idx: got %0d, required 0", bus.mshr_wr_idx); end
    step();
    bus.alloc = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h1000 || bus.mem_req_tag !== 3'd0) begin
      miscompares++;
      $display("FAIL one_req_latency: got v=%b addr=%h tag=%0d, required v=1 addr=00001000 tag=0",
               bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_tag);
    end
    step();
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL one_req_drop: got %b, required 0", bus.mem_req_valid); end
    step();
    step();
    respond(3'd0, 32'h1000);
    step();
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.fill_valid !== 1'b1 || bus.mshr_fin !== 1'b1 || bus.mshr_fin_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL one_fin: got fill=%b fin=%b idx=%0d, required 1 1 0", bus.fill_valid, bus.mshr_fin, bus.mshr_fin_idx);
    end
    step();
    @(negedge clk);
    vectors++;
    if (bus.fill_valid !== 1'b0 || bus.mshr_fin !== 1'b0 || bus.mshr_wr_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL one_free: got fill=%b fin=%b wr_idx=%0d, required 0 0 0", bus.fill_valid, bus.mshr_fin, bus.mshr_wr_idx);
    end
  endtask

  task automatic test_merge();
    step();
    bus.alloc = 1'b1;
    bus.alloc_addr = 32'h2004;
    exp_req.push_back('{32'h2000, 3'd0});
    @(negedge clk);
    vectors++;
    if (bus.mshr_wr_idx !== 3'd0) begin miscompares++; $display("FAIL merge_first_idx: got %0d, required 0", bus.mshr_wr_idx); end
    step();
    bus.alloc = 1'b0;
    step();
    bus.alloc = 1'b1;
    bus.alloc_addr = 32'h200C;
    @(negedge clk);
    vectors++;
    if (bus.mshr_wr_idx !== 3'd0 || bus.alloc_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL merge_second_idx: got idx=%0d ok=%b, required idx=0 ok=1", bus.mshr_wr_idx, bus.alloc_ok);
    end
    vectors++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h2000) begin
      miscompares++;
      $display("FAIL merge_req_hold: got v=%b addr=%h, required v=1 addr=00002000", bus.mem_req_valid, bus.mem_req_addr);
    end
    step();
    bus.alloc = 1'b0;
    bus.mem_req_ready = 1'b1;
    repeat (3) step();
    bus.mem_req_ready = 1'b0;
    respond(3'd0, 32'h2000);
    step();
    bus.mem_resp_valid = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      step();
      bus.alloc = 1'b1;
      bus.alloc_addr = 32'h3000 + 32'(i << 4);
      exp_req.push_back('{32'h3000 + 32'(i << 4), 3'(i)});
      @(negedge clk);
      vectors++;
      if (bus.mshr_wr_idx !== 3'(i) || bus.alloc_ok !== 1'b1) begin
        miscompares++;
        $display("FAIL full_fill_idx: got idx=%0d ok=%b, required idx=%0d ok=1", bus.mshr_wr_idx, bus.alloc_ok, i);
      end
    end
    step();
    bus.alloc = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.mshr_full !== 1'b1) begin miscompares++; $display("FAIL full_flag: got %b, required 1", bus.mshr_full); end
    step();
    bus.alloc = 1'b1;
    bus.alloc_addr = 32'h4000;
    @(negedge clk);
    vectors++;
    if (bus.alloc_ok !== 1'b0) begin miscompares++; $display("FAIL full_reject: got alloc_ok=%b, required 0", bus.alloc_ok); end
    step();
    bus.alloc_addr = 32'h3038;
    @(negedge clk);
    vectors++;
    if (bus.alloc_ok !== 1'b1 || bus.mshr_wr_idx !== 3'd3) begin
      miscompares++;
      $display("FAIL full_merge: got ok=%b idx=%0d, required ok=1 idx=3", bus.alloc_ok, bus.mshr_wr_idx);
    end
    vectors++;
    if (bus.mshr_full !== 1'b1 || bus.mem_req_tag !== 3'd0 || bus.mem_req_addr !== 32'h3000) begin
      miscompares++;
      $display("FAIL full_no_change: got full=%b tag=%0d addr=%h, required 1 0 00003000",
               bus.mshr_full, bus.mem_req_tag, bus.mem_req_addr);
    end
    step();
    bus.alloc = 1'b0;
    bus.mem_req_ready = 1'b1;
    repeat (10) step();
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      respond(3'(i), 32'h3000 + 32'(i << 4));
      step();
    end
    bus.mem_resp_valid = 1'b0;
    repeat (2) step();
    @(negedge clk);
    vectors++;
    if (bus.mshr_full !== 1'b0) begin miscompares++; $display("FAIL full_drain: got full=%b, required 0", bus.mshr_full); end
  endtask

  task automatic test_out_of_order();
    logic        held;
    logic [31:0] held_addr;
    held = 1'b0;
    held_addr = '0;
    for (int c = 0; c < 10; c++) begin
      step();
      bus.alloc = (c < 3);
      bus.alloc_addr = 32'h5000 + 32'(c << 4);
      bus.mem_req_ready = (c % 2 == 1);
      if (c < 3) exp_req.push_back('{32'h5000 + 32'(c << 4), 3'(c)});
      @(negedge clk);
      if (held) begin
        vectors++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== held_addr) begin
          miscompares++;
          $display("FAIL ooo_hold: got v=%b addr=%h, required v=1 addr=%h", bus.mem_req_valid, bus.mem_req_addr, held_addr);
        end
      end
      held = bus.mem_req_valid && !bus.mem_req_ready;
      held_addr = bus.mem_req_addr;
    end
    step();
    bus.alloc = 1'b0;
    bus.mem_req_ready = 1'b0;
    respond(3'd2, 32'h5020);
    step();
    respond(3'd0, 32'h5000);
    step();
    respond(3'd1, 32'h5010);
    step();
    bus.mem_resp_valid = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_fill_cycle_alloc();
    bus.mem_req_ready = 1'b1;
    bus.alloc = 1'b1;
    bus.alloc_addr = 32'h6000;
    exp_req.push_back('{32'h6000, 3'd0});
    step();
    bus.alloc = 1'b0;
    step();
    respond(3'd0, 32'h6000);
    step();
    bus.mem_resp_valid = 1'b0;
    bus.alloc = 1'b1;
    bus.alloc_addr = 32'h6008;
    @(negedge clk);
    vectors++;
    if (bus.mshr_fin !== 1'b1 || bus.mshr_fin_idx !== 3'd0 || bus.mshr_wr_idx !== 3'd0) begin
      miscompares++;
      $display("FAIL fillcyc_merge: got fin=%b fin_idx=%0d wr_idx=%0d, required 1 0 0",
               bus.mshr_fin, bus.mshr_fin_idx, bus.mshr_wr_idx);
    end
    step();
    bus.alloc = 1'b1;
    bus.alloc_addr = 32'h7000;
    exp_req.push_back('{32'h7000, 3'd0});
    step();
    bus.alloc = 1'b0;
    step();
    respond(3'd0, 32'h7000);
    step();
    bus.mem_resp_valid = 1'b0;
    bus.alloc = 1'b1;
    bus.alloc_addr = 32'h8000;
    exp_req.push_back('{32'h8000, 3'd1});
    @(negedge clk);
    vectors++;
    if (bus.mshr_fin_idx !== 3'd0 || bus.mshr_wr_idx !== 3'd1) begin
      miscompares++;
      $display("FAIL fillcyc_distinct: got fin_idx=%0d wr_idx=%0d, required 0 1", bus.mshr_fin_idx, bus.mshr_wr_idx);
    end
    step();
    bus.alloc_addr = 32'h9000;
    exp_req.push_back('{32'h9000, 3'd0});
    @(negedge clk);
    vectors++;
    if (bus.mshr_wr_idx !== 3'd0) begin miscompares++; $display("FAIL fillcyc_reuse: got wr_idx=%0d, required 0", bus.mshr_wr_idx); end
    step();
    bus.alloc = 1'b0;
    step();
    respond(3'd1, 32'h8000);
    step();
    respond(3'd0, 32'h9000);
    step();
    bus.mem_resp_valid = 1'b0;
    bus.mem_req_ready = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset_midflight();
    bus.mem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.alloc = 1'b1;
      bus.alloc_addr = 32'hA000 + 32'(i << 4);
      exp_req.push_back('{32'hA000 + 32'(i << 4), 3'(i)});
      step();
    end
    bus.alloc = 1'b0;
    bus.alloc_addr = 32'hB000;
    repeat (4) step();
    @(negedge clk);
    vectors++;
    if (bus.mshr_wr_idx !== 3'd4) begin miscompares++; $display("FAIL pend_wr_idx: got %0d, required 4", bus.mshr_wr_idx); end
    step();
    bus.mem_req_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.mshr_wr_idx !== 3'd0 || bus.mshr_full !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.alloc_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_state: got idx=%0d full=%b req=%b ok=%b, required 0 0 0 1",
               bus.mshr_wr_idx, bus.mshr_full, bus.mem_req_valid, bus.alloc_ok);
    end
    step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.mem_resp_valid = (i < 4);
      bus.mem_resp_tag = 3'(i);
      bus.mem_resp_data = '1;
      step();
      @(negedge clk);
      vectors++;
      if (bus.mshr_fin !== 1'b0 || bus.fill_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stale_resp: got fin=%b fill=%b, required 0 0", bus.mshr_fin, bus.fill_valid);
      end
    end
    bus.mem_resp_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    repeat (3) step();
    bus.mem_req_ready = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_one_miss();
    test_merge();
    test_full();
    test_out_of_order();
    test_fill_cycle_alloc();
    test_reset_midflight();
    vectors++;
    if (exp_req.size() != 0) begin miscompares++; $display("FAIL req_left: got %0d pending, required 0", exp_req.size()); end
    vectors++;
    if (exp_fin.size() != 0) begin miscompares++; $display("FAIL fin_left: got %0d pending, required 0", exp_fin.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
